ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data/instruction RAM between the instruction-fetch stage and the memory stage of the pipelined RV32I core. It accepts at most one request per cycle using a valid/ready handshake and drives the RAM's address, write-data, write-width and write-enable inputs. The RAM's one-cycle registered read latency is tracked with an owner register, so the registered read data is routed back to the requester that issued the access. By default the memory stage has fixed priority. An optional guard prevents fetch starvation.

---
 rtl/ram_arbiter_pkg.sv | 24 ++
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared core package used by the RAM arbiter.
// Provides the datapath width, the RAM store-width encoding and the
// arbiter owner encoding, which trace and debug tooling can also use.
package ram_arbiter_pkg;

    // Core datapath width (RV32I).
    localparam int XLEN = 32;

    // Store width presented to the RAM; loads ignore this field.
    typedef enum logic [1:0] {
        write_byte     = 2'd0,
        write_halfword = 2'd1,
        write_word     = 2'd2
    } write_width_t;

    // Which requester owns the RAM read data returning this cycle.
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        IFETCH  = 2'd1,
        DMEM_RD = 2'd2,
        DMEM_WR = 2'd3
    } ram_owner_t;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-ported RAM between instruction fetch and
// the memory stage. Grants are combinational. An owner register tracks the
// RAM's one-cycle read latency and steers the read data back to whichever
// requester issued the access.
//
// Optional feature: define RAM_ARB_STARVE_GUARD_EN to build the fetch
// starvation guard. After STARVE_LIMIT consecutive data grants won against a
// waiting fetch, fetch is forced through for one cycle. Without the macro,
// the data port has strict priority and no counter exists.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset_n,

    input  logic            ifetch_req_valid,
    output logic            ifetch_req_ready,
    input  logic [XLEN-1:0] ifetch_addr,
    output logic            ifetch_rsp_valid,
    output logic [XLEN-1:0] ifetch_rsp_data,

    input  logic            dmem_req_valid,
    output logic            dmem_req_ready,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_w_data,
    input  write_width_t    dmem_w_width,
    input  logic            dmem_w_enable,
    output logic            dmem_rsp_valid,
    output logic [XLEN-1:0] dmem_rsp_data,

    output logic [XLEN-1:0] ram_addr,
    output logic [XLEN-1:0] ram_w_data,
    output write_width_t    ram_w_width,
    output logic            ram_w_enable,
    input  logic [XLEN-1:0] ram_r_data
);

    // A zero limit would force fetch through on every contended cycle,
    // which is never what is intended.
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("ram_arbiter: STARVE_LIMIT must be at least 1");
    end

    logic       force_ifetch;   // starvation guard overrides data priority
    logic       dmem_grant;
    logic       ifetch_grant;
    ram_owner_t owner_q;
    ram_owner_t owner_d;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    // Fetch wins once it has lost STARVE_LIMIT contended cycles in a row.
    assign force_ifetch = ifetch_req_valid && dmem_req_valid &&
                          (starve_q == CNT_W'(STARVE_LIMIT));

    // Count data grants taken while fetch waits; any fetch grant or an
    // absent fetch request restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (!ifetch_req_valid || ifetch_grant) begin
            starve_d = '0;
        end else if (dmem_grant) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict data-port priority: fetch is never forced through.
    assign force_ifetch = 1'b0;
`endif

    // Data port wins contention unless the guard fires; fetch takes the RAM
    // whenever the data port does not.
    assign dmem_grant   = dmem_req_valid && !force_ifetch;
    assign ifetch_grant = ifetch_req_valid && !dmem_grant;

    assign dmem_req_ready   = dmem_grant;
    assign ifetch_req_ready = ifetch_grant;

    // RAM request mux and next owner selection.
    always_comb begin
        ram_addr     = '0;
        ram_w_data   = '0;
        ram_w_width  = write_word;
        ram_w_enable = 1'b0;
        owner_d      = NONE;
        if (dmem_grant) begin
            ram_addr     = dmem_addr;
            ram_w_data   = dmem_w_data;
            ram_w_width  = dmem_w_width;
            // Never let a store reach the RAM while reset is held.
            ram_w_enable = dmem_w_enable && reset_n;
            owner_d      = dmem_w_enable ? DMEM_WR : DMEM_RD;
        end else if (ifetch_grant) begin
            ram_addr = ifetch_addr;
            owner_d  = IFETCH;
        end
    end

    // Owner register: remembers who the RAM is answering next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Response steering from the owner; store acknowledges carry zero data.
    always_comb begin
        ifetch_rsp_valid = 1'b0;
        ifetch_rsp_data  = '0;
        dmem_rsp_valid   = 1'b0;
        dmem_rsp_data    = '0;
        unique case (owner_q)
            IFETCH: begin
                ifetch_rsp_valid = 1'b1;
                ifetch_rsp_data  = ram_r_data;
            end
            DMEM_RD: begin
                dmem_rsp_valid = 1'b1;
                dmem_rsp_data  = ram_r_data;
            end
            DMEM_WR: begin
                dmem_rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a table of per-cycle vectors plus
// hand-written reset and contention sequences. Expected responses are queued
// when a grant is expected and compared the cycle the DUT answers.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            ifetch_req_valid = 1'b0;
    logic            ifetch_req_ready;
    logic [XLEN-1:0] ifetch_addr = '0;
    logic            ifetch_rsp_valid;
    logic [XLEN-1:0] ifetch_rsp_data;
    logic            dmem_req_valid = 1'b0;
    logic            dmem_req_ready;
    logic [XLEN-1:0] dmem_addr = '0;
    logic [XLEN-1:0] dmem_w_data = '0;
    write_width_t    dmem_w_width = write_word;
    logic            dmem_w_enable = 1'b0;
    logic            dmem_rsp_valid;
    logic [XLEN-1:0] dmem_rsp_data;
    logic [XLEN-1:0] ram_addr;
    logic [XLEN-1:0] ram_w_data;
    write_width_t    ram_w_width;
    logic            ram_w_enable;
    logic [XLEN-1:0] ram_r_data = '0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic         ifv;
        logic [31:0]  ifa;
        logic         dv;
        logic [31:0]  da;
        logic [31:0]  dwd;
        write_width_t dww;
        logic         dwe;
        logic         eir;     // expected ifetch_req_ready
        logic         edr;     // expected dmem_req_ready
        logic [31:0]  eaddr;   // expected ram_addr
        logic         ewe;     // expected ram_w_enable
    } vec_t;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    vec_t        tbl [10];

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .ifetch_req_valid (ifetch_req_valid),
        .ifetch_req_ready (ifetch_req_ready),
        .ifetch_addr      (ifetch_addr),
        .ifetch_rsp_valid (ifetch_rsp_valid),
        .ifetch_rsp_data  (ifetch_rsp_data),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_addr        (dmem_addr),
        .dmem_w_data      (dmem_w_data),
        .dmem_w_width     (dmem_w_width),
        .dmem_w_enable    (dmem_w_enable),
        .dmem_rsp_valid   (dmem_rsp_valid),
        .dmem_rsp_data    (dmem_rsp_data),
        .ram_addr         (ram_addr),
        .ram_w_data       (ram_w_data),
        .ram_w_width      (ram_w_width),
        .ram_w_enable     (ram_w_enable),
        .ram_r_data       (ram_r_data)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)  return 32'hDEADBEEF;
        if (i == 8)  return 32'hC0DE0008;
        if (i == 16) return 32'h11223344;
        return {8'h5A, 8'(i), 8'hA5, 8'(i)};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] addr,
                                          input logic [31:0] wd, input write_width_t w);
        logic [31:0] r;
        r = old;
        case (w)
            write_byte:     r[8*addr[1:0] +: 8]  = wd[7:0];
            write_halfword: r[16*addr[1] +: 16]  = wd[15:0];
            default:        r = wd;
        endcase
        return r;
    endfunction

    // Behavioural single-port RAM with registered read.
    always @(posedge clock) begin
        if (ram_w_enable)
            mem[ram_addr[7:2]] <= merge(mem[ram_addr[7:2]], ram_addr, ram_w_data, ram_w_width);
        ram_r_data <= mem[ram_addr[7:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic ifv, input logic [31:0] ifa, input logic dv,
                                input logic [31:0] da, input logic [31:0] dwd,
                                input write_width_t dww, input logic dwe,
                                input logic eir, input logic edr,
                                input logic [31:0] eaddr, input logic ewe);
        vec_t v;
        v.ifv = ifv; v.ifa = ifa; v.dv = dv; v.da = da; v.dwd = dwd; v.dww = dww;
        v.dwe = dwe; v.eir = eir; v.edr = edr; v.eaddr = eaddr; v.ewe = ewe;
        return v;
    endfunction

    task automatic check_rsp(input string tag);
        rsp_t e;
        logic has;
        has = 1'b0;
        e.is_if = 1'b0;
        e.data  = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            has = 1'b1;
        end
        chk({tag, " if_rsp_valid"}, 32'(ifetch_rsp_valid), 32'(has && e.is_if));
        chk({tag, " if_rsp_data"}, ifetch_rsp_data, (has && e.is_if) ? e.data : 32'h0);
        chk({tag, " d_rsp_valid"}, 32'(dmem_rsp_valid), 32'(has && !e.is_if));
        chk({tag, " d_rsp_data"}, dmem_rsp_data, (has && !e.is_if) ? e.data : 32'h0);
    endtask

    // One cycle: drive after the edge, check responses and grant at negedge,
    // then queue the response expected next cycle.
    task automatic step(input vec_t v, input string tag);
        rsp_t e;
        @(posedge clock);
        #1;
        ifetch_req_valid = v.ifv;
        ifetch_addr      = v.ifa;
        dmem_req_valid   = v.dv;
        dmem_addr        = v.da;
        dmem_w_data      = v.dwd;
        dmem_w_width     = v.dww;
        dmem_w_enable    = v.dwe;
        @(negedge clock);
        check_rsp(tag);
        chk({tag, " if_ready"}, 32'(ifetch_req_ready), 32'(v.eir));
        chk({tag, " d_ready"}, 32'(dmem_req_ready), 32'(v.edr));
        chk({tag, " ram_addr"}, ram_addr, v.eaddr);
        chk({tag, " ram_we"}, 32'(ram_w_enable), 32'(v.ewe));
        if (v.edr) begin
            chk({tag, " ram_wdata"}, ram_w_data, v.dwd);
            chk({tag, " ram_width"}, 32'(ram_w_width), 32'(v.dww));
            e.is_if = 1'b0;
            e.data  = v.dwe ? 32'h0 : ref_mem[v.da[7:2]];
            sb.push_back(e);
            if (v.dwe) ref_mem[v.da[7:2]] = merge(ref_mem[v.da[7:2]], v.da, v.dwd, v.dww);
        end else if (v.eir) begin
            chk({tag, " ram_wdata"}, ram_w_data, 32'h0);
            chk({tag, " ram_width"}, 32'(ram_w_width), 32'(write_word));
            e.is_if = 1'b1;
            e.data  = ref_mem[v.ifa[7:2]];
            sb.push_back(e);
        end
        $display("step %s: if_rdy=%0b d_rdy=%0b addr=%h we=%0b", tag,
                 ifetch_req_ready, dmem_req_ready, ram_addr, ram_w_enable);
    endtask

    vec_t idle;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        idle = mk(0, 0, 0, 0, 0, write_word, 0, 0, 0, 32'h0, 0);

        // Vector table: fetch only, contention, store/load forwarding.
        tbl[0] = idle;
        tbl[1] = mk(1, 32'h10, 0, 0, 0, write_word, 0, 1, 0, 32'h10, 0);
        tbl[2] = mk(1, 32'h14, 1, 32'h20, 0, write_word, 0, 0, 1, 32'h20, 0);
        tbl[3] = mk(1, 32'h14, 0, 0, 0, write_word, 0, 1, 0, 32'h14, 0);
        tbl[4] = mk(0, 0, 1, 32'h41, 32'hAB, write_byte, 1, 0, 1, 32'h41, 1);
        tbl[5] = mk(0, 0, 1, 32'h40, 0, write_word, 0, 0, 1, 32'h40, 0);
        tbl[6] = idle;
        tbl[7] = mk(1, 32'h30, 1, 32'h0A, 32'hBEEF, write_halfword, 1, 0, 1, 32'h0A, 1);
        tbl[8] = mk(1, 32'h30, 1, 32'h08, 0, write_word, 0, 0, 1, 32'h08, 0);
        tbl[9] = mk(1, 32'h30, 0, 0, 0, write_word, 0, 1, 0, 32'h30, 0);

        // Reset state, with a store request present to prove the write gate.
        dmem_req_valid = 1'b1;
        dmem_w_enable  = 1'b1;
        dmem_addr      = 32'h44;
        repeat (2) @(negedge clock);
        chk("reset if_rsp_valid", 32'(ifetch_rsp_valid), 32'h0);
        chk("reset d_rsp_valid", 32'(dmem_rsp_valid), 32'h0);
        chk("reset if_rsp_data", ifetch_rsp_data, 32'h0);
        chk("reset d_rsp_data", dmem_rsp_data, 32'h0);
        chk("reset ram_we gated", 32'(ram_w_enable), 32'h0);
        chk("reset d_ready comb", 32'(dmem_req_ready), 32'h1);
        dmem_req_valid = 1'b0;
        dmem_w_enable  = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("vec%0d", i));
        step(idle, "flush");
        chk("store-load word", ref_mem[16], 32'h1122AB44);

        // Reset mid-flight: grant a fetch, then assert reset before the response.
        step(mk(1, 32'h18, 0, 0, 0, write_word, 0, 1, 0, 32'h18, 0), "pre_rst");
        #1 reset_n = 1'b0;
        sb.delete();
        ifetch_req_valid = 1'b0;
        #1;
        chk("midrst if_rsp_valid", 32'(ifetch_rsp_valid), 32'h0);
        chk("midrst d_rsp_valid", 32'(dmem_rsp_valid), 32'h0);
        @(posedge clock);
        @(negedge clock);
        chk("midrst post-edge if_rsp_valid", 32'(ifetch_rsp_valid), 32'h0);
        chk("midrst post-edge if_rsp_data", ifetch_rsp_data, 32'h0);
        chk("midrst ram_addr", ram_addr, 32'h0);
        reset_n = 1'b1;
        step(idle, "post_rst0");
        step(idle, "post_rst1");

        // Sustained contention: guard pattern D,D,D,D,I or strict data priority.
        for (int k = 0; k < 10; k++) begin
            logic iw;
`ifdef RAM_ARB_STARVE_GUARD_EN
            iw = (k % 5) == 4;
`else
            iw = 1'b0;
`endif
            step(mk(1, 32'h10, 1, 32'h20, 0, write_word, 0, iw, !iw,
                    iw ? 32'h10 : 32'h20, 0), $sformatf("contend%0d", k));
        end
        step(idle, "final");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_ram_arbiter
